// File: rtl/ddr_tg_pkg.sv
// Shared definitions for the DDR traffic generator: FSM states, AXI constants
// and the deterministic data pattern used by both the writer and the checker.
package ddr_tg_pkg;

    typedef enum logic [2:0] {
        IDLE,
        ADDR,
        DATA,
        DRAIN,
        DONE
    } state_e;

    localparam logic [1:0] RESP_OKAY = 2'b00;
    localparam logic [1:0] AXI_INCR  = 2'b01;

    // Widest beat the pattern function can produce; callers truncate to DATA_W.
    localparam int unsigned MAX_DATA_W = 1024;

    // Lane k (32 bits) of the beat at byte address addr is (addr + 4*k) ^ seed.
    function automatic logic [MAX_DATA_W-1:0] exp_beat(input logic [31:0] addr,
                                                       input logic [31:0] seed);
        logic [MAX_DATA_W-1:0] beat;
        for (int k = 0; k < int'(MAX_DATA_W / 32); k++) begin
            beat[k*32 +: 32] = (addr + 32'(4 * k)) ^ seed;
        end
        return beat;
    endfunction

endpackage

// File: rtl/sync_rise_det.sv
// Two-flop synchroniser for an asynchronous level, followed by a rising-edge pulse.
module sync_rise_det (
    input  logic clk,
    input  logic rst_n,
    input  logic d,
    output logic rise
);

    logic [2:0] sync_q;

    // Stages 0/1 synchronise, stage 2 holds the previous synchronised value.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            sync_q <= '0;
        end else begin
            sync_q <= {sync_q[1:0], d};
        end
    end

    assign rise = sync_q[1] & ~sync_q[2];

endmodule

// File: rtl/ddr_rd_checker.sv
// AXI4 read-back checker: reads NUM_BURSTS INCR bursts from BASE_ADDR, compares
// each beat against the shared pattern and reports done/pass/error count.
module ddr_rd_checker
    import ddr_tg_pkg::*;
#(
    parameter int unsigned        ADDR_W     = 40,
    parameter int unsigned        DATA_W     = 128,
    parameter int unsigned        ID_W       = 4,
    parameter int unsigned        BURST_LEN  = 16,
    parameter int unsigned        NUM_BURSTS = 256,
    parameter logic [ADDR_W-1:0]  BASE_ADDR  = '0,
    parameter logic [31:0]        SEED       = 32'hA5A5_0000,
    parameter int unsigned        WIDTH      = 8
) (
    input  logic              clk,
    input  logic              rst_n,
    input  logic              start,
    output logic [ADDR_W-1:0] m_araddr,
    output logic [7:0]        m_arlen,
    output logic [2:0]        m_arsize,
    output logic [1:0]        m_arburst,
    output logic [ID_W-1:0]   m_arid,
    output logic              m_arvalid,
    input  logic              m_arready,
    input  logic [DATA_W-1:0] m_rdata,
    input  logic [1:0]        m_rresp,
    input  logic              m_rlast,
    input  logic              m_rvalid,
    output logic              m_rready,
    output logic              done,
    output logic              pass,
    output logic [15:0]       err_cnt,
    output logic [WIDTH-1:0]  out
);

    localparam int unsigned BEAT_BYTES  = DATA_W / 8;
    localparam int unsigned BURST_BYTES = BURST_LEN * BEAT_BYTES;
    localparam int unsigned BEAT_W      = (BURST_LEN > 1) ? $clog2(BURST_LEN) : 1;
    localparam int unsigned BURST_W     = (NUM_BURSTS > 1) ? $clog2(NUM_BURSTS) : 1;
    localparam int unsigned OUT_F       = WIDTH - 2;
    localparam logic [31:0] OUT_MAX     = (32'd1 << OUT_F) - 32'd1;

    // Elaboration-time sanity checks on the configuration.
    if ((DATA_W % 32) != 0 || DATA_W > MAX_DATA_W) begin : g_bad_data_w
        $error("DATA_W must be a multiple of 32 and at most MAX_DATA_W");
    end
    if ((4096 % BURST_BYTES) != 0) begin : g_bad_burst
        $error("A burst must divide 4 KB so it never crosses a 4 KB boundary");
    end
    if ((32'(BASE_ADDR[11:0]) % BURST_BYTES) != 0) begin : g_bad_base
        $error("BASE_ADDR must be aligned to the burst size");
    end
    if (WIDTH < 3 || WIDTH > 18) begin : g_bad_width
        $error("WIDTH must be in 3..18");
    end

    state_e              state_q, state_d;
    logic [ADDR_W-1:0]   araddr_q, araddr_d;
    logic [31:0]         beat_addr_q, beat_addr_d;
    logic [BEAT_W-1:0]   beat_cnt_q, beat_cnt_d;
    logic [BURST_W-1:0]  burst_cnt_q, burst_cnt_d;
    logic [15:0]         err_cnt_q, err_cnt_d;
    logic                cmp_valid_q, cmp_valid_d;
    logic [DATA_W-1:0]   cmp_data_q, cmp_data_d;
    logic [DATA_W-1:0]   cmp_exp_q, cmp_exp_d;
    logic [1:0]          cmp_resp_q, cmp_resp_d;
    logic                cmp_last_q, cmp_last_d;
    logic                cmp_last_exp_q, cmp_last_exp_d;
    logic                start_rise;
    logic                last_beat;
    logic                mismatch;
    logic [31:0]         cnt32;

    sync_rise_det u_start_sync (
        .clk  (clk),
        .rst_n(rst_n),
        .d    (start),
        .rise (start_rise)
    );

    assign last_beat = (beat_cnt_q == BEAT_W'(BURST_LEN - 1));
    assign mismatch  = (cmp_data_q != cmp_exp_q) || (cmp_resp_q != RESP_OKAY) ||
                       (cmp_last_q != cmp_last_exp_q);

    // Next-state logic: FSM, address/beat/burst counters, registered compare.
    always_comb begin
        state_d        = state_q;
        araddr_d       = araddr_q;
        beat_addr_d    = beat_addr_q;
        beat_cnt_d     = beat_cnt_q;
        burst_cnt_d    = burst_cnt_q;
        err_cnt_d      = err_cnt_q;
        cmp_valid_d    = 1'b0;
        cmp_data_d     = cmp_data_q;
        cmp_exp_d      = cmp_exp_q;
        cmp_resp_d     = cmp_resp_q;
        cmp_last_d     = cmp_last_q;
        cmp_last_exp_d = cmp_last_exp_q;

        // Previous cycle's captured beat is judged here, at most one count per beat.
        if (cmp_valid_q && mismatch && (err_cnt_q != 16'hFFFF)) begin
            err_cnt_d = err_cnt_q + 16'd1;
        end

        unique case (state_q)
            IDLE, DONE: begin
                if (start_rise) begin
                    state_d     = ADDR;
                    araddr_d    = BASE_ADDR;
                    burst_cnt_d = '0;
                    err_cnt_d   = '0;
                end
            end
            ADDR: begin
                if (m_arready) begin
                    state_d     = DATA;
                    beat_addr_d = araddr_q[31:0];
                    beat_cnt_d  = '0;
                end
            end
            DATA: begin
                if (m_rvalid) begin
                    cmp_valid_d    = 1'b1;
                    cmp_data_d     = m_rdata;
                    cmp_exp_d      = DATA_W'(exp_beat(beat_addr_q, SEED));
                    cmp_resp_d     = m_rresp;
                    cmp_last_d     = m_rlast;
                    cmp_last_exp_d = last_beat;
                    beat_addr_d    = beat_addr_q + 32'(BEAT_BYTES);
                    beat_cnt_d     = beat_cnt_q + BEAT_W'(1);
                    // Burst length is counted locally; rlast only feeds the compare.
                    if (last_beat) begin
                        if (burst_cnt_q == BURST_W'(NUM_BURSTS - 1)) begin
                            state_d = DRAIN;
                        end else begin
                            state_d     = ADDR;
                            araddr_d    = araddr_q + ADDR_W'(BURST_BYTES);
                            burst_cnt_d = burst_cnt_q + BURST_W'(1);
                        end
                    end
                end
            end
            DRAIN: begin
                state_d = DONE;
            end
            default: begin
                state_d = IDLE;
            end
        endcase
    end

    // State registers; reset aborts a run without draining outstanding beats.
    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            state_q        <= IDLE;
            araddr_q       <= BASE_ADDR;
            beat_addr_q    <= '0;
            beat_cnt_q     <= '0;
            burst_cnt_q    <= '0;
            err_cnt_q      <= '0;
            cmp_valid_q    <= 1'b0;
            cmp_data_q     <= '0;
            cmp_exp_q      <= '0;
            cmp_resp_q     <= '0;
            cmp_last_q     <= 1'b0;
            cmp_last_exp_q <= 1'b0;
        end else begin
            state_q        <= state_d;
            araddr_q       <= araddr_d;
            beat_addr_q    <= beat_addr_d;
            beat_cnt_q     <= beat_cnt_d;
            burst_cnt_q    <= burst_cnt_d;
            err_cnt_q      <= err_cnt_d;
            cmp_valid_q    <= cmp_valid_d;
            cmp_data_q     <= cmp_data_d;
            cmp_exp_q      <= cmp_exp_d;
            cmp_resp_q     <= cmp_resp_d;
            cmp_last_q     <= cmp_last_d;
            cmp_last_exp_q <= cmp_last_exp_d;
        end
    end

    assign m_araddr  = araddr_q;
    assign m_arlen   = 8'(BURST_LEN - 1);
    assign m_arsize  = 3'($clog2(BEAT_BYTES));
    assign m_arburst = AXI_INCR;
    assign m_arid    = '0;
    assign m_arvalid = (state_q == ADDR);
    assign m_rready  = (state_q == DATA);
    assign done      = (state_q == DONE);
    assign pass      = done && (err_cnt_q == 16'd0);
    assign err_cnt   = err_cnt_q;
    assign cnt32     = {16'd0, err_cnt_q};

    // Status vector: error count clipped to the field width.
    always_comb begin
        out = '0;
        out[WIDTH-1] = done;
        out[WIDTH-2] = pass;
        if (cnt32 > OUT_MAX) begin
            out[OUT_F-1:0] = OUT_MAX[OUT_F-1:0];
        end else begin
            out[OUT_F-1:0] = cnt32[OUT_F-1:0];
        end
    end

endmodule
